// File: rtl/mem_ctrl.sv
// ============================================================================
// Module   : mem_ctrl
// Brief    : Single-outstanding memory slave serving a 16-bit word RAM and an
//            optional memory-mapped timer (built only when ZKTC_TIMER_EN is
//            defined) that drives the core's irq/ack pair.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mem_ctrl #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [15:0] MMIO_BASE  = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic [15:0] mem_addr,
  input  logic [1:0]  mem_wstrb,
  input  logic [15:0] mem_wdata,
  output logic        mem_ready,
  output logic [15:0] mem_rdata,
  output logic        irq,
  input  logic        ack
);

  localparam int         c_DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_ACCESS  = 2'd1;
  localparam logic [1:0] c_RESP    = 2'd2;
  localparam logic [1:0] c_RELEASE = 2'd3;

  logic [1:0]  r_state, w_next_state;
  logic [15:0] r_addr, r_wdata;
  logic [1:0]  r_wstrb;
  logic        w_is_ram;
  logic [15:0] w_io_rdata;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_IDLE;
      r_addr  <= '0;
      r_wstrb <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == c_IDLE && mem_valid) begin
        r_addr  <= mem_addr;
        r_wstrb <= mem_wstrb;
        r_wdata <= mem_wdata;
      end
    end
  end

  // RELEASE waits for the core to drop its request so it is never served twice
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:    if (mem_valid) w_next_state = c_ACCESS;
      c_ACCESS:  w_next_state = c_RESP;
      c_RESP:    w_next_state = c_RELEASE;
      c_RELEASE: if (!mem_valid) w_next_state = c_IDLE;
      default:   w_next_state = c_IDLE;
    endcase
  end

  logic [15:0] r_ram_q;

  always_comb begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (r_state == c_RESP) begin
      mem_ready = 1'b1;
      mem_rdata = w_is_ram ? r_ram_q : w_io_rdata;
    end
  end

  // ---------------------------------------------------------------- RAM
  logic [15:0]           r_ram [c_DEPTH];
  logic [ADDR_WIDTH-1:0] w_ram_idx;
  logic                  w_ram_access;

  assign w_is_ram     = ({16'h0, r_addr} < (32'd1 << ADDR_WIDTH));
  assign w_ram_idx    = r_addr[ADDR_WIDTH-1:0];
  assign w_ram_access = (r_state == c_ACCESS) && w_is_ram;

  // No reset on the array: contents survive a reset pulse
  always_ff @(posedge clk) begin
    if (w_ram_access) begin
      if (r_wstrb[0]) r_ram[w_ram_idx][7:0]  <= r_wdata[7:0];
      if (r_wstrb[1]) r_ram[w_ram_idx][15:8] <= r_wdata[15:8];
      r_ram_q <= r_ram[w_ram_idx];
    end
  end

`ifdef ZKTC_TIMER_EN
  // -------------------------------------------------------------- timer
  logic [15:0] w_mmio_off;
  logic        w_is_mmio, w_io_wr, w_hit, w_bus_clr, w_pend_clr;
  logic [15:0] r_tcnt, r_tcmp, r_io_q, w_io_sel, w_merged;
  logic        r_en, r_ie, r_pend, r_irq;

  assign w_mmio_off = r_addr - MMIO_BASE;
  assign w_is_mmio  = !w_is_ram && (w_mmio_off[15:2] == 14'd0);
  assign w_io_wr    = (r_state == c_ACCESS) && w_is_mmio && (r_wstrb != 2'b00);
  assign w_hit      = r_en && (r_tcnt == r_tcmp);
  assign w_bus_clr  = w_io_wr && (w_mmio_off[1:0] == 2'd2) && r_wstrb[0] && r_wdata[2];
  // A compare hit outranks any clear source in the same cycle
  assign w_pend_clr = (ack || w_bus_clr) && !w_hit;

  always_comb begin
    w_io_sel = '0;
    case (w_mmio_off[1:0])
      2'd0:    w_io_sel = r_tcnt;
      2'd1:    w_io_sel = r_tcmp;
      2'd2:    w_io_sel = {13'd0, r_pend, r_ie, r_en};
      default: w_io_sel = '0;
    endcase
    w_merged = w_io_sel;
    if (r_wstrb[0]) w_merged[7:0]  = r_wdata[7:0];
    if (r_wstrb[1]) w_merged[15:8] = r_wdata[15:8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
      r_tcmp <= '0;
      r_en   <= 1'b0;
      r_ie   <= 1'b0;
      r_pend <= 1'b0;
      r_irq  <= 1'b0;
      r_io_q <= '0;
    end else begin
      if (w_io_wr && w_mmio_off[1:0] == 2'd0) r_tcnt <= w_merged;
      else if (w_hit)                          r_tcnt <= '0;
      else if (r_en)                           r_tcnt <= r_tcnt + 16'd1;

      if (w_io_wr && w_mmio_off[1:0] == 2'd1) r_tcmp <= w_merged;
      if (w_io_wr && w_mmio_off[1:0] == 2'd2 && r_wstrb[0]) begin
        r_en <= r_wdata[0];
        r_ie <= r_wdata[1];
      end

      if (w_hit)           r_pend <= 1'b1;
      else if (w_pend_clr) r_pend <= 1'b0;

      r_irq <= r_pend && r_ie && !w_pend_clr;

      if (r_state == c_ACCESS) r_io_q <= w_is_mmio ? w_io_sel : 16'h0000;
    end
  end

  assign w_io_rdata = r_io_q;
  assign irq        = r_irq;
`else
  logic w_unused_ack;

  assign w_unused_ack = ack;
  assign w_io_rdata   = '0;
  assign irq          = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: vector table, held-request, timer and
// reset corner cases, plus randomized RAM traffic against an array model.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_ctrl;

  localparam logic [15:0] c_MMIO = 16'hFF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic [15:0] mem_addr;
  logic [1:0]  mem_wstrb;
  logic [15:0] mem_wdata;
  logic        mem_ready;
  logic [15:0] mem_rdata;
  logic        irq;
  logic        ack;

  int n_tests = 0;
  int n_fail  = 0;

  mem_ctrl #(.ADDR_WIDTH(12), .MMIO_BASE(c_MMIO)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .irq       (irq),
    .ack       (ack)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  wstrb;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus transaction. Cycle 0 raises mem_valid; mem_ready must appear only
  // in cycle 2 and mem_rdata must be 0 in every other observed cycle.
  task automatic bus_xfer(input logic [15:0] a, input logic [1:0] s, input logic [15:0] d,
                          input int hold, output logic [15:0] rd, output logic ok);
    ok = 1'b1;
    rd = '0;
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = a; mem_wstrb = s; mem_wdata = d;
    for (int c = 0; c <= 3 + hold; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        if (c == 3 + hold) begin
          mem_valid = 1'b0;
          mem_wstrb = 2'b00;
        end
      end
      @(negedge clk);
      if (c == 2) begin
        if (mem_ready !== 1'b1) ok = 1'b0;
        rd = mem_rdata;
      end else if (mem_ready !== 1'b0 || mem_rdata !== 16'h0000) begin
        ok = 1'b0;
      end
    end
  endtask

  task automatic xfer_chk(input string name, input logic [15:0] a, input logic [1:0] s,
                          input logic [15:0] d, input logic [15:0] exp);
    logic [15:0] rd;
    logic        ok;
    bus_xfer(a, s, d, 0, rd, ok);
    check16({name, "_timing"}, {15'd0, ok}, 16'd1);
    if (s == 2'b00) check16({name, "_rdata"}, rd, exp);
  endtask

  logic [15:0] model [8];

  initial begin
    logic [15:0] rd;
    logic        ok;

    vecs[0]  = '{16'h0010, 2'b11, 16'hBEEF, 16'h0000};
    vecs[1]  = '{16'h0010, 2'b00, 16'h0000, 16'hBEEF};
    vecs[2]  = '{16'h0010, 2'b01, 16'h0012, 16'h0000};
    vecs[3]  = '{16'h0010, 2'b00, 16'h0000, 16'hBE12};
    vecs[4]  = '{16'h0010, 2'b10, 16'h5600, 16'h0000};
    vecs[5]  = '{16'h0010, 2'b00, 16'hFFFF, 16'h5612};
    vecs[6]  = '{16'h8000, 2'b00, 16'h0000, 16'h0000};
    vecs[7]  = '{16'h8000, 2'b11, 16'hFFFF, 16'h0000};
    vecs[8]  = '{16'h8000, 2'b00, 16'h0000, 16'h0000};
    vecs[9]  = '{16'h0010, 2'b00, 16'h0000, 16'h5612};
    vecs[10] = '{16'h0FFF, 2'b11, 16'hA5C3, 16'h0000};
    vecs[11] = '{16'h1000, 2'b11, 16'h1111, 16'h0000};
    vecs[12] = '{16'h1000, 2'b00, 16'h0000, 16'h0000};
    vecs[13] = '{16'h0FFF, 2'b00, 16'h0000, 16'hA5C3};

    rst = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wstrb = '0; mem_wdata = '0; ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check16("reset_ready", {15'd0, mem_ready}, 16'd0);
    check16("reset_rdata", mem_rdata, 16'h0000);
    check16("reset_irq", {15'd0, irq}, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      xfer_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, vecs[i].exp);

    // Request held 4 extra cycles after its response: still one pulse only
    bus_xfer(16'h0030, 2'b11, 16'hC0DE, 4, rd, ok);
    check16("held_valid_timing", {15'd0, ok}, 16'd1);
    xfer_chk("held_followup", 16'h0030, 2'b00, 16'h0000, 16'hC0DE);

`ifdef ZKTC_TIMER_EN
    xfer_chk("tcmp_wr", c_MMIO + 16'd1, 2'b11, 16'd5, 16'h0);
    xfer_chk("tctrl_en", c_MMIO + 16'd2, 2'b11, 16'd3, 16'h0);
    // Offsets are cycles from the TCTRL request; EN takes effect at offset 2,
    // compare hits at 7/13/19, ack pulses at 10, 16 and 19 (the last one
    // coinciding with a hit, so PEND must survive it).
    for (int off = 3; off <= 22; off++) begin
      logic exp_irq;
      if (off > 3) begin
        @(posedge clk); #1;
        ack = (off == 10 || off == 16 || off == 19);
        @(negedge clk);
      end
      exp_irq = (off == 9 || off == 10 || off == 15 || off == 16 || off == 21 || off == 22);
      check16($sformatf("irq_off%0d", off), {15'd0, irq}, {15'd0, exp_irq});
    end
    @(posedge clk); #1;
    ack = 1'b0;
    xfer_chk("tcnt_running", c_MMIO, 2'b00, 16'h0, 16'd5);
    xfer_chk("tctrl_off", c_MMIO + 16'd2, 2'b11, 16'h0000, 16'h0);
    xfer_chk("tctrl_pend", c_MMIO + 16'd2, 2'b00, 16'h0, 16'h0004);
    xfer_chk("tctrl_clr", c_MMIO + 16'd2, 2'b01, 16'h0004, 16'h0);
    xfer_chk("tctrl_cleared", c_MMIO + 16'd2, 2'b00, 16'h0, 16'h0000);
    check16("irq_after_clr", {15'd0, irq}, 16'd0);
    xfer_chk("tcnt_wr", c_MMIO, 2'b11, 16'h1234, 16'h0);
    xfer_chk("tcnt_rd", c_MMIO, 2'b00, 16'h0, 16'h1234);
    xfer_chk("tcnt_bwr", c_MMIO, 2'b01, 16'h00AB, 16'h0);
    xfer_chk("tcnt_brd", c_MMIO, 2'b00, 16'h0, 16'h12AB);
    xfer_chk("tcmp_rd", c_MMIO + 16'd1, 2'b00, 16'h0, 16'd5);
    xfer_chk("reg3_wr", c_MMIO + 16'd3, 2'b11, 16'hFFFF, 16'h0);
    xfer_chk("reg3_rd", c_MMIO + 16'd3, 2'b00, 16'h0, 16'h0000);
`else
    xfer_chk("mmio_wr_cmp", c_MMIO + 16'd1, 2'b11, 16'd5, 16'h0);
    xfer_chk("mmio_wr_ctrl", c_MMIO + 16'd2, 2'b11, 16'd3, 16'h0);
    xfer_chk("mmio_rd_cmp", c_MMIO + 16'd1, 2'b00, 16'h0, 16'h0000);
    xfer_chk("mmio_rd_ctrl", c_MMIO + 16'd2, 2'b00, 16'h0, 16'h0000);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check16("irq_tied", {15'd0, irq}, 16'd0);
`endif

    // Randomized traffic: 8 RAM words at 0x0100 plus two unmapped addresses
    for (int i = 0; i < 8; i++) begin
      model[i] = 16'($urandom);
      xfer_chk($sformatf("rnd_init%0d", i), 16'h0100 + 16'(i), 2'b11, model[i], 16'h0);
    end
    for (int n = 0; n < 40; n++) begin
      int          sel;
      logic [15:0] a, d, exp;
      logic [1:0]  s;
      sel = $urandom_range(0, 9);
      a   = (sel < 8) ? 16'h0100 + 16'(sel) : ((sel == 8) ? 16'hF000 : 16'hFF10);
      s   = ($urandom_range(0, 1) == 1) ? 2'($urandom_range(1, 3)) : 2'b00;
      d   = 16'($urandom);
      exp = (sel < 8) ? model[sel] : 16'h0000;
      if (sel < 8 && s != 2'b00) begin
        if (s[0]) model[sel][7:0]  = d[7:0];
        if (s[1]) model[sel][15:8] = d[15:8];
      end
      xfer_chk($sformatf("rnd%0d", n), a, s, d, exp);
    end

    // Reset asserted while a write sits in ACCESS: the write must be lost
    xfer_chk("rst_pre_wr", 16'h0020, 2'b11, 16'h5A5A, 16'h0);
    @(posedge clk); #1;
    mem_valid = 1'b1; mem_addr = 16'h0020; mem_wstrb = 2'b11; mem_wdata = 16'h1234;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check16("rst_mid_ready", {15'd0, mem_ready}, 16'd0);
    check16("rst_mid_rdata", mem_rdata, 16'h0000);
    check16("rst_mid_irq", {15'd0, irq}, 16'd0);
    @(posedge clk);
    @(negedge clk);
    check16("rst_no_ready", {15'd0, mem_ready}, 16'd0);
    mem_valid = 1'b0; mem_wstrb = 2'b00; rst = 1'b0;
    xfer_chk("rst_post_rd", 16'h0020, 2'b00, 16'h0, 16'h5A5A);
    xfer_chk("rst_ram_kept", 16'h0010, 2'b00, 16'h0, 16'h5612);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-side slave that consumes the core's single-outstanding memory request bus. It serves instruction fetches and load/store/push/pop data accesses from an on-chip word RAM and a small memory-mapped timer. The timer drives the core's `irq` input and consumes its `ack` pulse. The block sits directly downstream of `core`, and its ports connect one-to-one to the core's `mem_*`, `irq` and `ack` signals.

## Interface
- `ADDR_WIDTH`, default 12: RAM depth is 2^ADDR_WIDTH 16-bit words, mapped at address 0 upward.
- `MMIO_BASE`, default 16'hFF00: base address of the timer registers (4-word window).
- `clk`  in  1  clock; rising edge only.
- `rst`  in  1  reset; asynchronous, active-high.
- `mem_valid`  in  1  request; held high by the core until it sees `mem_ready`.
- `mem_addr`  in  16  word address; each address holds one 16-bit word.
- `mem_wstrb`  in  2  byte write strobes; bit0 covers [7:0], bit1 covers [15:8]; 0 means read.
- `mem_wdata`  in  16  write data.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  16  read data, valid while `mem_ready`=1.
- `irq`  out  1  level interrupt request.
- `ack`  in  1  one-cycle interrupt acknowledge from the core.

## Operation
- FSM states and transitions:
  - IDLE: when `mem_valid`=1, latch addr/wstrb/wdata and go to ACCESS.
  - ACCESS: perform the RAM or MMIO read/write, then go to RESP.
  - RESP: `mem_ready`=1 and `mem_rdata` driven; go to RELEASE.
  - RELEASE: `mem_ready`=0; wait for `mem_valid`=0, then go to IDLE. A request still high in this state is never re-served.
- Address decode:
  - addr < 2^ADDR_WIDTH: RAM.
  - MMIO_BASE..MMIO_BASE+3: timer.
  - Anything else: reads return 16'h0000, writes are dropped, and `mem_ready` still pulses.
- Writes: each byte is written only when its strobe bit is set (2'b11 = word, 2'b01 = low byte). A read (wstrb=0) returns the full word.
- RAM is a synchronous single-port read/write array with no reset of its contents. A write commits at the ACCESS→RESP edge.
- Timer registers (word offsets from MMIO_BASE):
  - +0 TCNT: 16-bit counter, read/write.
  - +1 TCMP: 16-bit compare value, read/write.
  - +2 TCTRL: bit0 EN, bit1 IE, bit2 PEND. PEND is read-only except that writing 1 clears it. Other bits read 0.
  - +3: reads 0, writes ignored.
- Counting and compare:
  - When EN=1, TCNT increments every cycle.
  - When EN=1 and TCNT==TCMP, TCNT becomes 0 on the next edge (instead of incrementing) and PEND sets.
  - TCNT wraps 16'hFFFF→0 with no event.
- Interrupt: `irq` = PEND & IE, registered. `ack`=1 clears PEND.
- Simultaneous events:
  - PEND set and `ack` in the same cycle: set wins.
  - Bus write to TCNT and an increment in the same cycle: the write wins.
  - Bus clear of PEND and a compare hit in the same cycle: set wins.

## Timing
- Reset values: `mem_ready`=0, `mem_rdata`=0, `irq`=0, TCNT=TCMP=TCTRL=0, FSM=IDLE.
- Request latency: `mem_valid` first high in cycle t → `mem_ready`=1 for exactly cycle t+2.
- After the response, the core drops `mem_valid` in cycle t+3, the FSM is back in IDLE at t+4, and the next request can start at t+4.
- `mem_rdata` is valid only while `mem_ready`=1 and is 0 otherwise.
- A timer register write is visible to the counter and compare logic from the following cycle.
- `irq` follows PEND/IE with 1 cycle of latency. After `ack`, `irq` drops 1 cycle later.
- Reset asserted mid-transaction:
  - FSM returns to IDLE and no `mem_ready` is issued.
  - A write not yet at the ACCESS→RESP edge is lost.
  - RAM contents already written are retained.

## Configuration
- `ZKTC_TIMER_EN` defined: the timer is present as described above.
- `ZKTC_TIMER_EN` undefined: no timer logic is built.
  - The MMIO window decodes as unmapped: reads return 0, writes are dropped, `mem_ready` still pulses.
  - `irq` is tied to 0 and `ack` is ignored.
  - RAM behaviour and bus timing are unchanged.

## Test plan
- RAM word access: write 16'hBEEF to addr 16'h0010 (wstrb 11), then read addr 16'h0010 → rdata 16'hBEEF. Each `mem_ready` is high exactly 1 cycle, 2 cycles after `mem_valid`.
- Byte strobe: with 16'hBEEF at 16'h0010, write 16'h0012 with wstrb 01 → read returns 16'hBE12.
- Unmapped access: read 16'h8000 → rdata 0 and `mem_ready` pulses. A subsequent write there causes no change anywhere.
- Timer interrupt flow:
  - Setup: TCMP=5, TCTRL=3.
  - Expected: PEND sets 6 cycles after enable, `irq`=1 the next cycle, and TCNT restarts from 0.
  - Then pulse `ack` → `irq`=0 one cycle later. Repeat with `ack` coinciding with a compare hit → PEND stays 1.
- Held `mem_valid`: keep `mem_valid` high for 4 cycles after `mem_ready` → exactly one `mem_ready` pulse. Drop it → the next request is served normally.
- Reset mid-write: assert `rst` while in ACCESS for a write of 16'h1234 to 16'h0020 → no `mem_ready`, all outputs 0, and a subsequent read of 16'h0020 returns the old value.
